// File: rtl/scu_weight_packer.sv
// Sparse-weight encoder for scu: collects 48 dense beats (3 OC x 16 positions),
// keeps up to 6 nonzero weights per OC with their tile positions, emits one packet.
module scu_weight_packer #(
   parameter int W_bits = 16,
   parameter int I_bits = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W_bits-1:0]      in_weight,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [18*W_bits-1:0]   out_weights,
   output logic [18*I_bits-1:0]   out_indexes,
   output logic [2:0]             out_overflow
);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t              state, state_nxt;
   logic [5:0]          beat_cnt;
   logic [2:0]          nz [3];
   logic [W_bits-1:0]   slot_w [18];
   logic [I_bits-1:0]   slot_i [18];
   logic [2:0]          ovf;

   logic                accept;
   logic                release_pkt;
   logic                nonzero;
   logic [1:0]          oc;
   logic [3:0]          pos;
   logic [2:0]          nz_cur;
   logic [4:0]          wr_slot;

   always_comb begin
      in_ready    = (state == COLLECT);
      out_valid   = (state == EMIT);
      accept      = in_valid && in_ready;
      release_pkt = out_valid && out_ready;
      oc          = beat_cnt[5:4];
      pos         = beat_cnt[3:0];
      nonzero     = (in_weight != '0);
      case (oc)
         2'd0:    nz_cur = nz[0];
         2'd1:    nz_cur = nz[1];
         default: nz_cur = nz[2];
      endcase
      wr_slot = 5'(oc) * 5'd6 + 5'(nz_cur);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && beat_cnt == 6'd47) state_nxt = EMIT;
         EMIT:    if (out_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         ovf      <= '0;
         for (int unsigned c = 0; c < 3; c++) nz[c] <= '0;
         for (int unsigned k = 0; k < 18; k++) begin
            slot_w[k] <= '0;
            slot_i[k] <= '0;
         end
      end else if (release_pkt) begin
         ovf <= '0;
         for (int unsigned c = 0; c < 3; c++) nz[c] <= '0;
         for (int unsigned k = 0; k < 18; k++) begin
            slot_w[k] <= '0;
            slot_i[k] <= '0;
         end
      end else if (accept) begin
         beat_cnt <= (beat_cnt == 6'd47) ? '0 : beat_cnt + 6'd1;
         if (nonzero) begin
            // Per-OC fill count selects the slot; a full OC drops the beat and flags overflow.
            if (nz_cur < 3'd6) begin
               for (int unsigned k = 0; k < 18; k++) begin
                  if (wr_slot == 5'(k)) begin
                     slot_w[k] <= in_weight;
                     slot_i[k] <= I_bits'(pos);
                  end
               end
               for (int unsigned c = 0; c < 3; c++)
                  if (oc == 2'(c)) nz[c] <= nz_cur + 3'd1;
            end else begin
               for (int unsigned c = 0; c < 3; c++)
                  if (oc == 2'(c)) ovf[c] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      out_weights = '0;
      out_indexes = '0;
      for (int unsigned k = 0; k < 18; k++) begin
         out_weights[k*W_bits +: W_bits] = slot_w[k];
         out_indexes[k*I_bits +: I_bits] = slot_i[k];
      end
      out_overflow = ovf;
   end

endmodule
